// File: rtl/l1_miss_responder_pkg.sv
// Shared types for the L1 load-miss responder: request/response fields and
// the response FSM state encoding.
package l1_miss_responder_pkg;

  localparam int THREADS_PER_CORE = 4;
  localparam int IDX_W            = $clog2(THREADS_PER_CORE);
  localparam int LINE_ADR_W       = 26;
  localparam int LINE_W           = 512;

  typedef logic [LINE_ADR_W-1:0] cache_line_index_t;
  typedef logic [IDX_W-1:0]      l1_miss_entry_idx_t;
  typedef logic [LINE_W-1:0]     cache_line_data_t;

  typedef struct packed {
    cache_line_index_t  adr;
    l1_miss_entry_idx_t idx;
    logic               sync;
  } l1_miss_request_t;

  localparam int REQ_W = $bits(l1_miss_request_t);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } resp_state_t;

endpackage

// File: rtl/l1_miss_responder_sync_fifo.sv
// Circular request buffer with power-of-two depth; pointers wrap naturally and
// count runs 0..DEPTH. Pushes into a full buffer are dropped.
module l1_miss_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it was
  // written, and leaving it out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/l1_miss_responder.sv
// Far end of the L1 load-miss protocol: buffers miss requests, fetches each
// line over a single-outstanding read port and returns in-order responses.
module l1_miss_responder
  import l1_miss_responder_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dequeue_ready,
  output logic               dequeue_ack,
  input  cache_line_index_t  dequeue_adr,
  input  l1_miss_entry_idx_t dequeue_idx,
  input  logic               dequeue_sync,
  output logic               mem_read_en,
  output cache_line_index_t  mem_read_addr,
  input  logic               mem_read_ack,
  input  logic               mem_read_valid,
  input  cache_line_data_t   mem_read_data,
  output logic               l2_response_valid,
  output l1_miss_entry_idx_t l2_response_idx,
  output cache_line_index_t  l2_response_adr,
  output logic               l2_response_sync,
  output cache_line_data_t   l2_response_data,
  output logic               idle
);

  localparam int CNT_W = $clog2(REQ_FIFO_DEPTH) + 1;

  resp_state_t      state_q, state_d;
  l1_miss_request_t push_req, head;
  cache_line_data_t data_q;
  logic             fifo_full, fifo_empty, pop, capture;
  logic [CNT_W-1:0] fifo_count;

  assign dequeue_ack = dequeue_ready && !fifo_full && !reset;
  assign push_req    = '{adr: dequeue_adr, idx: dequeue_idx, sync: dequeue_sync};

  l1_miss_responder_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dequeue_ack),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The head stays in the buffer until RESPOND so its fields feed the response.
  always_ff @(posedge clk) begin
    if (capture) data_q <= mem_read_data;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    mem_read_en       = 1'b0;
    l2_response_valid = 1'b0;
    pop               = 1'b0;
    capture           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_read_en = 1'b1;
        if (mem_read_ack) begin
          if (mem_read_valid) begin
            capture = 1'b1;
            state_d = S_RESPOND;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_read_valid) begin
          capture = 1'b1;
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        l2_response_valid = 1'b1;
        pop               = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payload outputs are zeroed outside their valid window so nothing stale or
  // uninitialised from the buffer leaks onto the interfaces.
  assign mem_read_addr    = mem_read_en       ? head.adr : '0;
  assign l2_response_idx  = l2_response_valid ? head.idx : '0;
  assign l2_response_adr  = l2_response_valid ? head.adr : '0;
  assign l2_response_sync = l2_response_valid ? head.sync : 1'b0;
  assign l2_response_data = l2_response_valid ? data_q : '0;
  assign idle             = fifo_empty && (state_q == S_IDLE);

`ifndef SYNTHESIS
  logic                        reset_q;
  logic [THREADS_PER_CORE-1:0] in_flight;

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      in_flight <= '0;
    end else begin
      if (pop)         in_flight[head.idx]    <= 1'b0;
      if (dequeue_ack) in_flight[dequeue_idx] <= 1'b1;
      assert (!(dequeue_ack && in_flight[dequeue_idx] &&
                !(pop && head.idx == dequeue_idx)));
      assert (!(dequeue_ack && fifo_count == CNT_W'(REQ_FIFO_DEPTH)));
      assert (!(state_q == S_IDLE && mem_read_valid && !reset_q));
    end
  end
`endif

endmodule

// File: tb/tb_l1_miss_responder.sv
// Directed bench for l1_miss_responder: a behavioural memory, a response
// scoreboard fed from accepted requests, and hand-computed expectations.
module tb_l1_miss_responder;
  import l1_miss_responder_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               dequeue_ready;
  logic               dequeue_ack;
  cache_line_index_t  dequeue_adr;
  l1_miss_entry_idx_t dequeue_idx;
  logic               dequeue_sync;
  logic               mem_read_en;
  cache_line_index_t  mem_read_addr;
  logic               mem_read_ack;
  logic               mem_read_valid;
  cache_line_data_t   mem_read_data;
  logic               l2_response_valid;
  l1_miss_entry_idx_t l2_response_idx;
  cache_line_index_t  l2_response_adr;
  logic               l2_response_sync;
  cache_line_data_t   l2_response_data;
  logic               idle;

  always #5 clk = ~clk;

  l1_miss_responder dut (
    .clk               (clk),
    .reset             (reset),
    .dequeue_ready     (dequeue_ready),
    .dequeue_ack       (dequeue_ack),
    .dequeue_adr       (dequeue_adr),
    .dequeue_idx       (dequeue_idx),
    .dequeue_sync      (dequeue_sync),
    .mem_read_en       (mem_read_en),
    .mem_read_addr     (mem_read_addr),
    .mem_read_ack      (mem_read_ack),
    .mem_read_valid    (mem_read_valid),
    .mem_read_data     (mem_read_data),
    .l2_response_valid (l2_response_valid),
    .l2_response_idx   (l2_response_idx),
    .l2_response_adr   (l2_response_adr),
    .l2_response_sync  (l2_response_sync),
    .l2_response_data  (l2_response_data),
    .idle              (idle)
  );

  int checks = 0;
  int errors = 0;

  l1_miss_request_t  exp_q[$];
  l1_miss_request_t  mon_e;
  int                ack_cnt = 0;
  int                resp_cnt = 0;
  int                cyc_cnt = 0;
  int                last_ack_cyc = 0;
  int                last_resp_cyc = 0;
  logic              mem_stall = 1'b0;
  logic              mem_noreturn = 1'b0;
  logic              use_a5 = 1'b0;
  int                mem_lat = -1;
  int                inject_req = 0;
  int                inject_done = 0;
  int                served = 0;
  int                m_lat;
  cache_line_index_t m_addr;
  cache_line_index_t last_mem_addr = '0;
  int                lat_tab [10] = '{0, 5, 1, 3, 2, 4, 0, 1, 5, 2};

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cache_line_data_t line_of(input cache_line_index_t a, input logic a5);
    if (a5) return {64{8'hA5}};
    return {16{6'b101010, a}};
  endfunction

  // Memory model: acks whenever a read is requested, returns data after the
  // chosen latency (0 = same cycle as ack).
  initial begin
    mem_read_ack   = 1'b0;
    mem_read_valid = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      mem_read_ack   = 1'b0;
      mem_read_valid = 1'b0;
      if (inject_req != inject_done) begin
        inject_done    = inject_req;
        mem_read_valid = 1'b1;
        mem_read_data  = '1;
      end else if (mem_read_en && !mem_stall) begin
        m_addr        = mem_read_addr;
        last_mem_addr = m_addr;
        m_lat         = (mem_lat >= 0) ? mem_lat : lat_tab[served % 10];
        served++;
        mem_read_ack  = 1'b1;
        if (!mem_noreturn) begin
          if (m_lat == 0) begin
            mem_read_valid = 1'b1;
            mem_read_data  = line_of(m_addr, use_a5);
          end else begin
            @(negedge clk);
            mem_read_ack = 1'b0;
            repeat (m_lat - 1) @(negedge clk);
            mem_read_valid = 1'b1;
            mem_read_data  = line_of(m_addr, use_a5);
          end
        end
      end
    end
  end

  // Response monitor and in-order scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (l2_response_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc_cnt;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_idx", l2_response_idx, mon_e.idx);
          check("resp_adr", l2_response_adr, mon_e.adr);
          check("resp_sync", l2_response_sync, mon_e.sync);
          check("resp_data", l2_response_data, line_of(mon_e.adr, use_a5));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic rdy, input cache_line_index_t adr, input l1_miss_entry_idx_t idx,
                     input logic sy);
    l1_miss_request_t r;
    @(negedge clk);
    dequeue_ready = rdy;
    dequeue_adr   = adr;
    dequeue_idx   = idx;
    dequeue_sync  = sy;
    #1;
    if (dequeue_ack) begin
      r.adr  = adr;
      r.idx  = idx;
      r.sync = sy;
      exp_q.push_back(r);
      ack_cnt++;
      last_ack_cyc = cyc_cnt;
    end
  endtask

  task automatic send(input cache_line_index_t adr, input l1_miss_entry_idx_t idx, input logic sy);
    int a0 = ack_cnt;
    int n  = 0;
    while (ack_cnt == a0 && n < 100) begin
      cyc(1'b1, adr, idx, sy);
      n++;
    end
    if (ack_cnt == a0) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    do begin
      cyc(1'b0, '0, '0, 1'b0);
      n++;
    end while (!(idle && exp_q.size() == 0) && n < 400);
    check(tag, (idle && exp_q.size() == 0), 1'b1);
  endtask

  int r0;
  int n;

  initial begin
    reset         = 1'b1;
    dequeue_ready = 1'b1;
    dequeue_adr   = '0;
    dequeue_idx   = '0;
    dequeue_sync  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", dequeue_ack, 1'b0);
    check("rst_mem_en", mem_read_en, 1'b0);
    check("rst_resp_valid", l2_response_valid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_mem_addr", mem_read_addr, '0);
    check("rst_resp_idx", l2_response_idx, '0);
    check("rst_resp_adr", l2_response_adr, '0);
    check("rst_resp_data", l2_response_data, '0);
    @(negedge clk);
    reset         = 1'b0;
    dequeue_ready = 1'b0;

    // Single request, memory latency 3, A5 fill.
    use_a5  = 1'b1;
    mem_lat = 3;
    ack_cnt = 0;
    r0      = resp_cnt;
    send(26'h0001234, 2'd2, 1'b0);
    drain("single_drain");
    check("single_acks", ack_cnt, 1);
    check("single_mem_addr", last_mem_addr, 26'h0001234);
    check("single_resps", resp_cnt - r0, 1);
    use_a5 = 1'b0;

    // Fill while memory stalls: four acks, then none.
    mem_stall = 1'b1;
    mem_lat   = 2;
    ack_cnt   = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) cyc(1'b1, cache_line_index_t'(32'h100 + k), l1_miss_entry_idx_t'(k), 1'b0);
      else       cyc(1'b1, 26'h0000200, 2'd0, 1'b0);
    end
    check("fill_acks", ack_cnt, 4);
    check("fill_ack_low", dequeue_ack, 1'b0);
    mem_stall = 1'b0;
    r0        = resp_cnt;
    n         = 0;
    while (resp_cnt == r0 && n < 50) begin
      cyc(1'b1, 26'h0000200, 2'd0, 1'b0);
      n++;
    end
    mem_stall = 1'b1;
    check("fill_first_resp", resp_cnt - r0, 1);
    ack_cnt = 0;
    repeat (8) cyc(1'b1, 26'h0000200, 2'd0, 1'b0);
    check("refill_acks", ack_cnt, 1);
    mem_stall = 1'b0;
    drain("fill_drain");

    // Ten in-order requests with varied memory latency; pointers wrap twice.
    mem_lat = -1;
    r0      = resp_cnt;
    for (int k = 0; k < 10; k++)
      send(cache_line_index_t'(32'h0ABCDE0 + k * 32'h1111), l1_miss_entry_idx_t'(k % 4), k[0]);
    drain("order_drain");
    check("order_resps", resp_cnt - r0, 10);

    // Sync echo at full-width address.
    mem_lat = 1;
    r0      = resp_cnt;
    send(26'h3FFFFFF, 2'd1, 1'b1);
    drain("sync_drain");
    check("sync_resps", resp_cnt - r0, 1);

    // Reset while waiting on memory with two entries buffered.
    mem_noreturn = 1'b1;
    send(26'h0000011, 2'd0, 1'b0);
    send(26'h0000022, 2'd1, 1'b0);
    repeat (5) cyc(1'b0, '0, '0, 1'b0);
    check("pre_reset_busy", idle, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    inject_req++;
    @(negedge clk);
    reset        = 1'b0;
    mem_noreturn = 1'b0;
    r0           = resp_cnt;
    #1;
    check("post_reset_idle", idle, 1'b1);
    repeat (6) cyc(1'b0, '0, '0, 1'b0);
    check("post_reset_no_resp", resp_cnt - r0, 0);
    check("post_reset_idle_hold", idle, 1'b1);
    send(26'h0000033, 2'd3, 1'b1);
    drain("post_reset_drain");
    check("post_reset_resps", resp_cnt - r0, 1);

    // Ack and valid in the same cycle: response three cycles after accept.
    mem_lat = 0;
    r0      = resp_cnt;
    send(26'h1555555, 2'd2, 1'b1);
    drain("same_cycle_drain");
    check("same_cycle_resps", resp_cnt - r0, 1);
    check("same_cycle_latency", last_resp_cyc - last_ack_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
